// File: rtl/hz_display_pkg.sv
// Shared definitions for the 16x16 glyph display path.
// Provides geometry constants, the scanner state encoding, the fetched
// glyph-row payload and ROM address helpers.
package hz_display_pkg;

    localparam int unsigned GLYPH_BYTES = 32;
    localparam int unsigned ROWS        = 16;
    localparam int unsigned COLS        = 16;
    localparam int unsigned ADDR_W      = 7;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned ROW_W       = $clog2(ROWS);
    localparam int unsigned OFFS_W      = $clog2(COLS);
    localparam int unsigned CHAR_W      = 2;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        LOAD,
        DWELL
    } state_t;

    // One display row of the current glyph followed by the same row of the next glyph.
    typedef struct packed {
        logic [BYTE_W-1:0] cur_hi;
        logic [BYTE_W-1:0] cur_lo;
        logic [BYTE_W-1:0] nxt_hi;
        logic [BYTE_W-1:0] nxt_lo;
    } glyph_pair_t;

    // First byte address of a glyph.
    function automatic logic [ADDR_W-1:0] glyph_base(input logic [CHAR_W-1:0] ch);
        return ADDR_W'(ch) * ADDR_W'(GLYPH_BYTES);
    endfunction

    // Address of the left-half byte of a given row inside a glyph.
    function automatic logic [ADDR_W-1:0] row_byte_addr(input logic [CHAR_W-1:0] ch,
                                                        input logic [ROW_W-1:0]  row);
        return glyph_base(ch) + ADDR_W'({row, 1'b0});
    endfunction

endpackage

// File: rtl/hz_row_window.sv
// Combinational 16-pixel window selector over a 32-pixel strip.
// Ports:
//   data     - 32-pixel strip, bit 31 = leftmost pixel
//   offset   - number of pixels the window is moved right into the strip
//   window_c - 16 pixels starting at pixel 'offset', bit 15 = leftmost
module hz_row_window
    import hz_display_pkg::*;
(
    input  logic [2*COLS-1:0] data,
    input  logic [OFFS_W-1:0] offset,
    output logic [COLS-1:0]   window_c
);

    // Shift left then keep the top half of the strip.
    always_comb begin
        window_c = COLS'((data << offset) >> COLS);
    end

endmodule

// File: rtl/hz_matrix_scanner.sv
// Row-multiplexed driver for a 16x16 LED matrix showing a horizontally
// scrolling text strip read from the glyph ROM.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   en          - display enable
//   rom_addr    - glyph ROM byte address (ROM data returns one cycle later)
//   rom_data    - glyph ROM read data
//   row_n       - active-low one-hot row select
//   col         - active-high column data, bit 15 = leftmost pixel
//   frame_done  - one-cycle pulse after the last row's dwell
module hz_matrix_scanner
    import hz_display_pkg::*;
#(
    parameter int unsigned NUM_CHARS       = 3,
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned FRAMES_PER_STEP = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [BYTE_W-1:0] rom_data,
    output logic [ROWS-1:0]   row_n,
    output logic [COLS-1:0]   col,
    output logic              frame_done
);

    localparam int unsigned DWELL_W = 16;
    localparam int unsigned FRAME_W = 8;
    localparam int unsigned PHASE_W = 3;

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES_PER_STEP - 1);
    localparam logic [CHAR_W-1:0]  CHAR_LAST  = CHAR_W'(NUM_CHARS - 1);
    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic [OFFS_W-1:0]  OFFS_LAST  = OFFS_W'(COLS - 1);

    state_t             state,     state_d;
    logic [PHASE_W-1:0] phase,     phase_d;
    logic [ROW_W-1:0]   row,       row_d;
    logic [CHAR_W-1:0]  chr,       chr_d;
    logic [OFFS_W-1:0]  offset,    offset_d;
    logic [FRAME_W-1:0] frame_cnt, frame_cnt_d;
    logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_d;
    glyph_pair_t        glyph,     glyph_d;
    logic [ADDR_W-1:0]  rom_addr_d;
    logic [ROWS-1:0]    row_n_d;
    logic [COLS-1:0]    col_d;
    logic               frame_done_d;
    logic [CHAR_W-1:0]  nxt_chr;
    logic [COLS-1:0]    window_c;

    hz_row_window u_window (
        .data     (glyph),
        .offset   (offset),
        .window_c (window_c)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            phase      <= '0;
            row        <= '0;
            chr        <= '0;
            offset     <= '0;
            frame_cnt  <= '0;
            dwell_cnt  <= '0;
            glyph      <= '0;
            rom_addr   <= '0;
            row_n      <= '1;
            col        <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            phase      <= phase_d;
            row        <= row_d;
            chr        <= chr_d;
            offset     <= offset_d;
            frame_cnt  <= frame_cnt_d;
            dwell_cnt  <= dwell_cnt_d;
            glyph      <= glyph_d;
            rom_addr   <= rom_addr_d;
            row_n      <= row_n_d;
            col        <= col_d;
            frame_done <= frame_done_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d      = state;
        phase_d      = phase;
        row_d        = row;
        chr_d        = chr;
        offset_d     = offset;
        frame_cnt_d  = frame_cnt;
        dwell_cnt_d  = dwell_cnt;
        glyph_d      = glyph;
        rom_addr_d   = rom_addr;
        row_n_d      = row_n;
        col_d        = col;
        frame_done_d = 1'b0;

        // With a single glyph the next glyph is the current one.
        nxt_chr = (chr == CHAR_LAST) ? '0 : chr + CHAR_W'(1);

        if (!en) begin
            // Blank immediately; scroll position is kept so re-enable resumes the same row.
            state_d     = IDLE;
            row_n_d     = '1;
            col_d       = '0;
            dwell_cnt_d = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_d    = FETCH;
                    phase_d    = '0;
                    rom_addr_d = row_byte_addr(chr, row);
                    row_n_d    = '1;
                    col_d      = '0;
                end

                // Address leads data by one cycle: each phase captures the byte
                // addressed in the previous phase.
                FETCH: begin
                    phase_d = phase + PHASE_W'(1);
                    case (phase)
                        3'd0: rom_addr_d = rom_addr + ADDR_W'(1);
                        3'd1: begin
                            glyph_d.cur_hi = rom_data;
                            rom_addr_d     = row_byte_addr(nxt_chr, row);
                        end
                        3'd2: begin
                            glyph_d.cur_lo = rom_data;
                            rom_addr_d     = rom_addr + ADDR_W'(1);
                        end
                        3'd3: glyph_d.nxt_hi = rom_data;
                        default: begin
                            glyph_d.nxt_lo = rom_data;
                            state_d        = LOAD;
                        end
                    endcase
                end

                LOAD: begin
                    row_n_d     = ~(ROWS'(1) << row);
                    col_d       = window_c;
                    dwell_cnt_d = '0;
                    state_d     = DWELL;
                end

                DWELL: begin
                    if (dwell_cnt == DWELL_LAST) begin
                        dwell_cnt_d = '0;
                        row_d       = row + ROW_W'(1);
                        state_d     = FETCH;
                        phase_d     = '0;
                        row_n_d     = '1;
                        // Scroll position only moves between frames.
                        if (row == ROW_LAST) begin
                            frame_done_d = 1'b1;
                            if (frame_cnt == FRAME_LAST) begin
                                frame_cnt_d = '0;
                                offset_d    = offset + OFFS_W'(1);
                                if (offset == OFFS_LAST) begin
                                    chr_d = nxt_chr;
                                end
                            end else begin
                                frame_cnt_d = frame_cnt + FRAME_W'(1);
                            end
                        end
                        rom_addr_d = row_byte_addr(chr_d, row_d);
                    end else begin
                        dwell_cnt_d = dwell_cnt + DWELL_W'(1);
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hz_matrix_scanner.sv
// Self-checking bench for hz_matrix_scanner with a behavioural glyph ROM.
module tb_hz_matrix_scanner;

    localparam int unsigned NUM_CHARS = 3;
    localparam int unsigned SCAN_DIV  = 4;
    localparam int unsigned FPS       = 1;

    typedef struct packed {
        logic [15:0] row_n;
        logic [15:0] col;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [6:0]  rom_addr;
    logic [7:0]  rom_data;
    logic [15:0] row_n;
    logic [15:0] col;
    logic        frame_done;

    logic [7:0]  rom_mem [128];
    exp_t        sb [$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fd_count = 0;
    logic [15:0] prev_row_n = 16'hFFFF;

    int m_row, m_char, m_off, m_frame, m_fcnt;

    hz_matrix_scanner #(
        .NUM_CHARS       (NUM_CHARS),
        .SCAN_DIV        (SCAN_DIV),
        .FRAMES_PER_STEP (FPS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .row_n      (row_n),
        .col        (col),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Glyph ROM: registered read, one-cycle latency.
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    // Expected window built pixel by pixel from the 32-pixel strip.
    function automatic logic [15:0] calc_col(input int r, input int c, input int o);
        int n;
        logic [7:0] strip [4];
        logic [15:0] res;
        n = (c + 1) % NUM_CHARS;
        strip[0] = rom_mem[c*32 + r*2];
        strip[1] = rom_mem[c*32 + r*2 + 1];
        strip[2] = rom_mem[n*32 + r*2];
        strip[3] = rom_mem[n*32 + r*2 + 1];
        res = '0;
        for (int j = 0; j < 16; j++) begin
            int p;
            p = o + j;
            res[15-j] = strip[p/8][7-(p%8)];
        end
        return res;
    endfunction

    function automatic void model_reset();
        m_row = 0; m_char = 0; m_off = 0; m_frame = 0; m_fcnt = 0;
    endfunction

    function automatic void push_row();
        exp_t e;
        e.row_n = ~(16'd1 << m_row);
        e.col   = calc_col(m_row, m_char, m_off);
        sb.push_back(e);
        m_row++;
        if (m_row == 16) begin
            m_row = 0;
            m_frame++;
            m_fcnt++;
            if (m_fcnt == FPS) begin
                m_fcnt = 0;
                m_off++;
                if (m_off == 16) begin
                    m_off  = 0;
                    m_char = (m_char + 1) % NUM_CHARS;
                end
            end
        end
    endfunction

    function automatic void push_until(input int f, input int r);
        for (int k = 0; k < 2000 && !(m_frame == f && m_row == r); k++) push_row();
    endfunction

    // Scoreboard: each new lit row is compared against the oldest expectation.
    always @(negedge clk) begin
        cyc++;
        if (frame_done === 1'b1) fd_count++;
        if (rst_n === 1'b1 && prev_row_n === 16'hFFFF && row_n !== 16'hFFFF) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL row_onset: unexpected row_n=%h col=%h", row_n, col);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (row_n !== e.row_n || col !== e.col) begin
                    bad++;
                    $display("FAIL row_onset: got row_n=%h col=%h want row_n=%h col=%h",
                             row_n, col, e.row_n, e.col);
                end
            end
        end
        prev_row_n = row_n;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_row(input logic [15:0] target, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            step();
            if (row_n === target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_fd(input int n, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            step();
            if (fd_count >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_q_empty(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        bit ok;
        int n;
        logic [6:0] exp_addr [4];
        exp_addr = '{7'd0, 7'd1, 7'd32, 7'd33};
        rst_n = 1'b0;
        en    = 1'b1;
        sb.delete();
        model_reset();
        repeat (3) step();
        total++; if (rom_addr !== 7'd0)     begin bad++; $display("FAIL rst_addr: got %h want 00", rom_addr); end
        total++; if (row_n !== 16'hFFFF)    begin bad++; $display("FAIL rst_row_n: got %h want ffff", row_n); end
        total++; if (col !== 16'h0000)      begin bad++; $display("FAIL rst_col: got %h want 0000", col); end
        total++; if (frame_done !== 1'b0)   begin bad++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
        push_until(0, 2);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (rom_addr !== exp_addr[i]) begin
                bad++; $display("FAIL first_addr[%0d]: got %0d want %0d", i, rom_addr, exp_addr[i]);
            end
        end
        step();
        step();
        total++; if (row_n !== 16'hFFFF) begin bad++; $display("FAIL load_blank: got %h want ffff", row_n); end
        step();
        total++; if (row_n !== 16'hFFFE) begin bad++; $display("FAIL first_lit_row: got %h want fffe", row_n); end
        total++; if (col !== 16'h1000)   begin bad++; $display("FAIL first_lit_col: got %h want 1000", col); end
        n = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            n++;
            if (row_n === 16'hFFFD) break;
        end
        total++; if (n != 10) begin bad++; $display("FAIL row_period: got %0d want 10", n); end
        wait_q_empty(50, ok);
        total++; if (!ok) begin bad++; $display("FAIL reset_drain: got %0d pending want 0", sb.size()); end
    endtask

    task automatic test_row_fetch();
        bit ok;
        logic [6:0] exp_addr [4];
        exp_addr = '{7'd14, 7'd15, 7'd46, 7'd47};
        push_until(0, 8);
        wait_row(16'hFFBF, 100, ok);
        total++; if (!ok) begin bad++; $display("FAIL row6_wait: got timeout want row6 lit"); end
        wait_row(16'hFFFF, 20, ok);
        total++; if (!ok) begin bad++; $display("FAIL row7_fetch_wait: got timeout want blank"); end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            total++;
            if (rom_addr !== exp_addr[i]) begin
                bad++; $display("FAIL row7_addr[%0d]: got %0d want %0d", i, rom_addr, exp_addr[i]);
            end
        end
        wait_row(16'hFF7F, 10, ok);
        total++; if (!ok) begin bad++; $display("FAIL row7_lit: got row_n=%h want ff7f", row_n); end
        total++; if (col !== 16'h3892) begin bad++; $display("FAIL row7_col: got %h want 3892", col); end
        wait_q_empty(50, ok);
        total++; if (!ok) begin bad++; $display("FAIL row7_drain: got %0d pending want 0", sb.size()); end
    endtask

    task automatic test_scroll();
        bit ok;
        int c0;
        push_until(3, 1);
        wait_fd(1, 400, ok);
        total++; if (!ok) begin bad++; $display("FAIL fd1_wait: got timeout want pulse"); end
        c0 = cyc;
        step();
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL fd_width: got %b want 0", frame_done); end
        wait_fd(2, 400, ok);
        total++; if (cyc - c0 != 160) begin bad++; $display("FAIL fd_period: got %0d want 160", cyc - c0); end
        wait_fd(3, 400, ok);
        wait_row(16'hFFFE, 20, ok);
        total++; if (!ok) begin bad++; $display("FAIL off3_lit: got row_n=%h want fffe", row_n); end
        total++; if (col !== 16'h8000) begin bad++; $display("FAIL off3_col: got %h want 8000", col); end
        wait_q_empty(50, ok);
        total++; if (!ok) begin bad++; $display("FAIL scroll_drain: got %0d pending want 0", sb.size()); end
    endtask

    task automatic test_char_wrap();
        bit ok;
        logic [6:0] addr_c2 [4];
        logic [6:0] addr_c0 [4];
        addr_c2 = '{7'd64, 7'd65, 7'd0, 7'd1};
        addr_c0 = '{7'd0, 7'd1, 7'd32, 7'd33};
        push_until(32, 1);
        wait_fd(32, 6000, ok);
        total++; if (!ok) begin bad++; $display("FAIL fd32_wait: got %0d pulses want 32", fd_count); end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            total++;
            if (rom_addr !== addr_c2[i]) begin
                bad++; $display("FAIL char2_addr[%0d]: got %0d want %0d", i, rom_addr, addr_c2[i]);
            end
        end
        wait_row(16'hFFFE, 20, ok);
        total++; if (col !== 16'h1FE0) begin bad++; $display("FAIL char2_off0_col: got %h want 1fe0", col); end
        push_until(40, 1);
        wait_fd(40, 2000, ok);
        wait_row(16'hFFFE, 20, ok);
        total++; if (col !== 16'hE010) begin bad++; $display("FAIL char2_off8_col: got %h want e010", col); end
        push_until(48, 1);
        wait_fd(48, 2000, ok);
        total++; if (!ok) begin bad++; $display("FAIL fd48_wait: got %0d pulses want 48", fd_count); end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            total++;
            if (rom_addr !== addr_c0[i]) begin
                bad++; $display("FAIL char_wrap_addr[%0d]: got %0d want %0d", i, rom_addr, addr_c0[i]);
            end
        end
        wait_row(16'hFFFE, 20, ok);
        total++; if (col !== 16'h1000) begin bad++; $display("FAIL char_wrap_col: got %h want 1000", col); end
        wait_q_empty(50, ok);
        total++; if (!ok) begin bad++; $display("FAIL wrap_drain: got %0d pending want 0", sb.size()); end
    endtask

    task automatic test_en_drop();
        bit ok;
        logic [15:0] col_before;
        push_until(48, 6);
        wait_row(16'hFFDF, 100, ok);
        total++; if (!ok) begin bad++; $display("FAIL row5_wait: got timeout want row5 lit"); end
        col_before = col;
        step();
        en = 1'b0;
        step();
        total++; if (row_n !== 16'hFFFF)  begin bad++; $display("FAIL drop_row_n: got %h want ffff", row_n); end
        total++; if (col !== 16'h0000)    begin bad++; $display("FAIL drop_col: got %h want 0000", col); end
        total++; if (rom_addr !== 7'd43)  begin bad++; $display("FAIL drop_addr_hold: got %0d want 43", rom_addr); end
        repeat (3) step();
        total++; if (row_n !== 16'hFFFF)  begin bad++; $display("FAIL idle_hold: got %h want ffff", row_n); end
        m_row = 5;
        push_until(48, 7);
        en = 1'b1;
        step();
        total++; if (rom_addr !== 7'd10)  begin bad++; $display("FAIL reen_addr: got %0d want 10", rom_addr); end
        wait_row(16'hFFDF, 20, ok);
        total++; if (!ok) begin bad++; $display("FAIL reen_lit: got row_n=%h want ffdf", row_n); end
        total++; if (col !== col_before) begin bad++; $display("FAIL reen_col: got %h want %h", col, col_before); end
        wait_q_empty(50, ok);
        total++; if (!ok) begin bad++; $display("FAIL drop_drain: got %0d pending want 0", sb.size()); end
    endtask

    task automatic test_async_reset();
        bit ok;
        push_until(48, 8);
        wait_row(16'hFF7F, 100, ok);
        wait_row(16'hFFFF, 20, ok);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (rom_addr !== 7'd0)   begin bad++; $display("FAIL async_addr: got %0d want 0", rom_addr); end
        total++; if (row_n !== 16'hFFFF)  begin bad++; $display("FAIL async_row_n: got %h want ffff", row_n); end
        total++; if (col !== 16'h0000)    begin bad++; $display("FAIL async_col: got %h want 0000", col); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL async_fd: got %b want 0", frame_done); end
        sb.delete();
        model_reset();
        push_until(0, 2);
        step();
        rst_n = 1'b1;
        repeat (7) step();
        total++; if (row_n !== 16'hFFFE) begin bad++; $display("FAIL restart_row_n: got %h want fffe", row_n); end
        total++; if (col !== 16'h1000)   begin bad++; $display("FAIL restart_col: got %h want 1000", col); end
        wait_q_empty(50, ok);
        total++; if (!ok) begin bad++; $display("FAIL restart_drain: got %0d pending want 0", sb.size()); end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        for (int a = 0; a < 128; a++) rom_mem[a] = 8'((a * 73 + 29) ^ (a >> 2));
        rom_mem[0]  = 8'h10; rom_mem[1]  = 8'h00;
        rom_mem[14] = 8'h38; rom_mem[15] = 8'h92;
        rom_mem[32] = 8'h00; rom_mem[33] = 8'h40;
        rom_mem[64] = 8'h1F; rom_mem[65] = 8'hE0;
        model_reset();
        test_reset();
        test_row_fetch();
        test_scroll();
        test_char_wrap();
        test_en_drop();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
